// File: rtl/sb_pkg.sv
// Shared definitions for the store buffer: default geometry, the layout of
// one buffered entry, and the per-cycle memory-port arbitration states.
package sb_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 16;
  localparam int SB_DW    = 16;

  // One buffered store at the default widths.
  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

  // Owner of the data-memory port for the current cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2
  } sb_arb_e;

endpackage

// File: rtl/sb_queue.sv
// Circular store queue: entry array, head/tail pointers, occupancy count and
// a youngest-match address lookup used for store-to-load forwarding.
// Pointers wrap modulo DEPTH, so DEPTH must be a power of two.
module sb_queue
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [AW-1:0]            push_addr_i,
  input  logic [DW-1:0]            push_data_i,
  input  logic                     pop_i,
  input  logic [AW-1:0]            lookup_addr_i,
  output logic [AW-1:0]            head_addr_o,
  output logic [DW-1:0]            head_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     hit_o,
  output logic [DW-1:0]            hit_data_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addrMem_q [DEPTH];
  logic [DW-1:0] dataMem_q [DEPTH];
  logic [PW-1:0] headPtr_q, headPtr_d;
  logic [PW-1:0] tailPtr_q, tailPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] scanIdx;

  // Pointer and occupancy next state; a push and pop together keep the count.
  always_comb begin
    headPtr_d = headPtr_q;
    tailPtr_d = tailPtr_q;
    count_d   = count_q;
    if (push_i) begin
      tailPtr_d = tailPtr_q + PW'(1);
    end
    if (pop_i) begin
      headPtr_d = headPtr_q + PW'(1);
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers; reset discards every buffered entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      headPtr_q <= '0;
      tailPtr_q <= '0;
      count_q   <= '0;
    end else begin
      headPtr_q <= headPtr_d;
      tailPtr_q <= tailPtr_d;
      count_q   <= count_d;
    end
  end

  // Entry storage is only meaningful for slots covered by the count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push_i) begin
      addrMem_q[tailPtr_q] <= push_addr_i;
      dataMem_q[tailPtr_q] <= push_data_i;
    end
  end

  // Walk live entries oldest to youngest so the last match (the youngest) wins.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    scanIdx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scanIdx = headPtr_q + PW'(i);
      if ((CW'(i) < count_q) && (addrMem_q[scanIdx] == lookup_addr_i)) begin
        hit_o      = 1'b1;
        hit_data_o = dataMem_q[scanIdx];
      end
    end
  end

  assign head_addr_o = addrMem_q[headPtr_q];
  assign head_data_o = dataMem_q[headPtr_q];
  assign count_o     = count_q;

endmodule

// File: rtl/store_buffer.sv
// Store buffer in front of a single-port data memory. Stores are queued and
// drained whenever no load owns the port; loads bypass the queue, and a
// starvation guard forces one drain after DEPTH back-to-back loads while
// stores are waiting.
// Optional feature macro: STORE_FWD_EN -- loads may proceed while stores are
// buffered and take their data from the youngest matching entry. Without it
// loads wait for the buffer to empty and always read memory.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  input  logic [AW-1:0]            st_addr,
  input  logic [DW-1:0]            st_data,
  output logic                     st_ready,
  input  logic                     ld_valid,
  input  logic [AW-1:0]            ld_addr,
  output logic                     ld_ready,
  output logic                     ld_done,
  output logic [DW-1:0]            ld_data,
  output logic                     mem_write,
  output logic                     mem_read,
  output logic [AW-1:0]            mem_address,
  output logic [DW-1:0]            mem_write_data,
  input  logic [DW-1:0]            mem_read_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int CW = $clog2(DEPTH) + 1;

  sb_arb_e       arbState;
  logic          ldReadyBase;
  logic          guardActive;
  logic          ldAccept;
  logic          pushEn;
  logic          popEn;
  logic [AW-1:0] headAddr;
  logic [DW-1:0] headData;
  logic          fwdHit;
  logic [DW-1:0] fwdData;
  logic [DW-1:0] loadResult;
  logic          ldDone_q, ldDone_d;
  logic [DW-1:0] ldData_q, ldData_d;
  logic [CW-1:0] starveCnt_q, starveCnt_d;

  sb_queue #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_queue (
    .clk           (clk),
    .rst           (rst),
    .push_i        (pushEn),
    .push_addr_i   (st_addr),
    .push_data_i   (st_data),
    .pop_i         (popEn),
    .lookup_addr_i (ld_addr),
    .head_addr_o   (headAddr),
    .head_data_o   (headData),
    .count_o       (count),
    .hit_o         (fwdHit),
    .hit_data_o    (fwdData)
  );

  assign empty       = (count == '0);
  assign st_ready    = (count < CW'(DEPTH));
  assign guardActive = (starveCnt_q == CW'(DEPTH));

`ifdef STORE_FWD_EN
  assign ldReadyBase = 1'b1;
  assign loadResult  = fwdHit ? fwdData : mem_read_data;
`else
  logic unusedFwd;
  assign ldReadyBase = empty;
  assign loadResult  = mem_read_data;
  assign unusedFwd   = fwdHit ^ (^fwdData);
`endif

  assign ld_ready = ldReadyBase && !guardActive;
  assign ldAccept = ld_valid && ld_ready && !rst;
  assign pushEn   = st_valid && st_ready;
  assign popEn    = (arbState == DRAIN);

  // Pick the port owner: an accepted load wins, otherwise drain if anything is
  // buffered. Reset idles the port so discarded stores never reach memory.
  always_comb begin
    arbState = IDLE;
    if (ldAccept) begin
      arbState = LOAD;
    end else if (!rst && !empty) begin
      arbState = DRAIN;
    end
  end

  // Drive the memory port from the arbitration result; idle cycles drive zeros.
  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    case (arbState)
      LOAD: begin
        mem_read    = 1'b1;
        mem_address = ld_addr;
      end
      DRAIN: begin
        mem_write      = 1'b1;
        mem_address    = headAddr;
        mem_write_data = headData;
      end
      default: begin
        mem_read = 1'b0;
      end
    endcase
  end

  // Load result capture and starvation count: the run of loads that hold off
  // waiting stores grows only on LOAD cycles with a non-empty buffer.
  always_comb begin
    ldDone_d    = 1'b0;
    ldData_d    = ldData_q;
    starveCnt_d = '0;
    if (arbState == LOAD) begin
      ldDone_d = 1'b1;
      ldData_d = loadResult;
      if (!empty) begin
        starveCnt_d = starveCnt_q + CW'(1);
      end
    end
  end

  // Load result and starvation registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ldDone_q    <= 1'b0;
      ldData_q    <= '0;
      starveCnt_q <= '0;
    end else begin
      ldDone_q    <= ldDone_d;
      ldData_q    <= ldData_d;
      starveCnt_q <= starveCnt_d;
    end
  end

  assign ld_done = ldDone_q;
  assign ld_data = ldData_q;

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered store entries (power of two, 2..16).
REQ-002 Parameter AW, default 16, address width in words.
REQ-003 Parameter DW, default 16, data width.
REQ-004 The block SHALL have one clock, clk; reset rst is synchronous and active-high.
REQ-005 Ports SHALL be as follows:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- st_valid  in  1  store request
- st_addr  in  AW  store word address
- st_data  in  DW  store data
- st_ready  out  1  store accepted when st_valid && st_ready
- ld_valid  in  1  load request
- ld_addr  in  AW  load word address
- ld_ready  out  1  load accepted when ld_valid && ld_ready
- ld_done  out  1  one-cycle pulse, ld_data valid
- ld_data  out  DW  load result
- mem_write  out  1  to data memory write enable
- mem_read  out  1  to data memory read enable
- mem_address  out  AW  to data memory address
- mem_write_data  out  DW  to data memory write data
- mem_read_data  in  DW  from data memory, combinational read
- empty  out  1  no buffered stores
- count  out  $clog2(DEPTH)+1  buffered entry count

Function
REQ-006 st_ready SHALL equal (count < DEPTH), independent of a same-cycle drain.
REQ-007 An accepted store SHALL be written at the tail and count incremented at the next edge.
REQ-008 Per-cycle arbitration SHALL have three states: LOAD when a load is accepted, DRAIN when no load is accepted and count > 0, and IDLE otherwise.
REQ-009 In LOAD, mem_read SHALL be 1, mem_write 0, and mem_address = ld_addr.
REQ-010 In DRAIN, mem_write SHALL be 1, mem_read 0, mem_address/mem_write_data = head entry, and the head SHALL pop at the edge.
REQ-011 In IDLE, all mem_* outputs SHALL be 0.
REQ-012 A simultaneous store accept and drain SHALL leave count unchanged.
REQ-013 ld_done SHALL pulse exactly one cycle after acceptance, with ld_data registered at the accepting edge.
REQ-014 ld_data SHALL be the youngest buffered entry matching ld_addr, else mem_read_data.
REQ-015 A store accepted in the same cycle as a load SHALL be treated as younger and SHALL NOT be forwarded to that load.
REQ-016 Starvation guard: a counter SHALL count consecutive LOAD cycles with count > 0.
REQ-017 When that counter reaches DEPTH, ld_ready SHALL be 0 for one cycle, forcing DRAIN.
REQ-018 The starvation counter SHALL clear on any non-LOAD cycle.
REQ-019 Head and tail pointers SHALL wrap modulo DEPTH.
REQ-020 ld_data SHALL hold its value between ld_done pulses.

Reset
REQ-021 On rst, the block SHALL set count=0, pointers=0, ld_done=0, ld_data=0 and starvation counter=0, and drive empty=1.
REQ-022 Buffered stores present at rst SHALL be discarded and SHALL NOT be written to memory.
REQ-023 A load accepted in the cycle rst is asserted SHALL produce no ld_done.

Configuration
REQ-024 With STORE_FWD_EN defined, ld_ready SHALL be 1 except during a starvation-guard cycle, and forwarding per REQ-014 applies.
REQ-025 Without STORE_FWD_EN, ld_ready SHALL equal empty, so loads stall until the buffer drains, and ld_data SHALL always be mem_read_data.

Structure
REQ-026 Package sb_pkg SHALL hold the default DEPTH/AW/DW constants, the entry typedef {addr, data}, and the arbitration state enum {IDLE, DRAIN, LOAD}.
REQ-027 Sub-module sb_queue SHALL implement the circular entry array, pointers, count, and youngest-match lookup; store_buffer SHALL hold arbitration, the starvation guard and the load result register.

Verification
REQ-028 Bench SHALL cover: stores to 3,5,7 with no loads -> mem_write on three consecutive cycles in order, then empty=1.
REQ-029 Bench SHALL cover: fill 4 stores while ld_valid is held high -> st_ready=0 at count=4; after 4 LOAD cycles ld_ready=0 for one cycle and one DRAIN occurs.
REQ-030 Bench SHALL cover (STORE_FWD_EN): store 0x1234 then 0xBEEF to addr 5, then load 5 -> ld_done next cycle with ld_data=0xBEEF, and mem_read asserted.
REQ-031 Bench SHALL cover: store to addr 9 and load addr 9 in the same cycle, with memory holding 0x0042 -> ld_data=0x0042.
REQ-032 Bench SHALL cover (no STORE_FWD_EN): load issued with count=2 -> ld_ready=0 for 2 cycles, then accepted.
REQ-033 Bench SHALL cover: assert rst with count=3 -> count=0 and no further mem_write.
